// File: rtl/denise_bitplane_engine.sv
// denise_bitplane_engine: buffers per-plane fetch words, loads them into
// parallel-to-serial shifters on a plane-0 write, and delays each plane's
// pixel stream by the per-playfield scroll through a tapped history line.
module denise_bitplane_engine #(
  parameter int NPLANES = 8,
  parameter int DW      = 64,
  parameter int SCRW    = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               wr,
  input  logic [2:0]         wr_plane,
  input  logic [DW-1:0]      wr_data,
  input  logic [1:0]         fmode,
  input  logic [1:0]         res,
  input  logic [3:0]         nplanes_act,
  input  logic [SCRW-1:0]    scroll_odd,
  input  logic [SCRW-1:0]    scroll_even,
  output logic [NPLANES-1:0] bpldata,
  output logic               load_pulse,
  output logic               underrun
);

  localparam int HD = 2 ** SCRW;

  logic [DW-1:0]      plane_buf [NPLANES];
  logic [DW-1:0]      shifter   [NPLANES];
  logic [HD-1:0]      hist      [NPLANES];
  logic [NPLANES-1:0] fresh;
  logic [NPLANES-1:0] fresh_next;
  logic [NPLANES-1:0] wr_hit;
  logic [1:0]         phase;
  logic [SCRW-1:0]    scr_o;
  logic [SCRW-1:0]    scr_e;
  logic               load_r;
  logic               shift_en;
  logic               stale;

  // Keep only the top fetch-width bits of a word; narrower fetches leave the
  // tail of the shifter zero so an exhausted word reads as background.
  function automatic logic [DW-1:0] fetch_mask(input logic [1:0] fm);
    int w;
    logic [DW-1:0] m;
    case (fm)
      2'b00:   w = 16;
      2'b11:   w = 64;
      default: w = 32;
    endcase
    for (int i = 0; i < DW; i++) m[i] = (i + w >= DW);
    return m;
  endfunction

  // Decode the write strobe into a one-hot plane select; out-of-range planes
  // are dropped, and fresh flags restart at load except for a same-cycle write.
  always_comb begin
    wr_hit = '0;
    for (int p = 0; p < NPLANES; p++)
      wr_hit[p] = wr && (int'(wr_plane) == p);
    fresh_next = (load_r ? '0 : fresh) | wr_hit;
  end

  // Shift cadence derived from the free-running pixel phase.
  always_comb begin
    shift_en = 1'b1;
    case (res)
      2'b00:   shift_en = (phase == 2'd3);
      2'b01:   shift_en = phase[0];
      default: shift_en = 1'b1;
    endcase
  end

  // An enabled plane other than plane 0 that was not refreshed since the
  // previous load makes this load an underrun.
  always_comb begin
    stale = 1'b0;
    for (int p = 1; p < NPLANES; p++)
      if ((p < int'(nplanes_act)) && !fresh[p]) stale = 1'b1;
  end

  assign load_pulse = load_r;
  assign underrun   = load_r & stale;

  // Fetch buffers: capture masked words from the DMA write port.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int p = 0; p < NPLANES; p++) plane_buf[p] <= '0;
    end else begin
      for (int p = 0; p < NPLANES; p++)
        if (wr_hit[p]) plane_buf[p] <= wr_data & fetch_mask(fmode);
    end
  end

  // Control: fresh tracking, load arm, pixel phase and latched scroll.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fresh  <= '0;
      load_r <= 1'b0;
      phase  <= 2'd0;
      scr_o  <= '0;
      scr_e  <= '0;
    end else begin
      fresh  <= fresh_next;
      load_r <= wr_hit[0];
      phase  <= load_r ? 2'd0 : phase + 2'd1;
      if (load_r) begin
        scr_o <= scroll_odd;
        scr_e <= scroll_even;
      end
    end
  end

  // Shifters: parallel load takes priority over the zero-fill left shift.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int p = 0; p < NPLANES; p++) shifter[p] <= '0;
    end else begin
      for (int p = 0; p < NPLANES; p++) begin
        if (load_r)        shifter[p] <= plane_buf[p];
        else if (shift_en) shifter[p] <= {shifter[p][DW-2:0], 1'b0};
      end
    end
  end

  // Delay line: record every shifter output pixel for the scroll taps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int p = 0; p < NPLANES; p++) hist[p] <= '0;
    end else begin
      for (int p = 0; p < NPLANES; p++)
        hist[p] <= {hist[p][HD-2:0], shifter[p][DW-1]};
    end
  end

  // Output taps: odd playfield on even plane indices, gated by plane count.
  always_comb begin
    bpldata = '0;
    for (int p = 0; p < NPLANES; p++)
      bpldata[p] = (p < int'(nplanes_act)) &&
                   ((p % 2 == 0) ? hist[p][scr_o] : hist[p][scr_e]);
  end

endmodule

// File: tb/tb_denise_bitplane_engine.sv
// Bench for denise_bitplane_engine: directed scenarios plus randomized
// traffic, checked cycle by cycle against a pixel-timeline reference model.
module tb_denise_bitplane_engine;

  localparam int NP   = 8;
  localparam int DW   = 64;
  localparam int SCRW = 8;
  localparam int RING = 4096;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            wr = 1'b0;
  logic [2:0]      wr_plane = 3'd0;
  logic [DW-1:0]   wr_data = '0;
  logic [1:0]      fmode = 2'd0;
  logic [1:0]      res = 2'd0;
  logic [3:0]      nplanes_act = 4'd0;
  logic [SCRW-1:0] scroll_odd = '0;
  logic [SCRW-1:0] scroll_even = '0;
  logic [NP-1:0]   bpldata;
  logic            load_pulse;
  logic            underrun;

  denise_bitplane_engine #(.NPLANES(NP), .DW(DW), .SCRW(SCRW)) dut (
    .clk(clk), .reset_n(reset_n), .wr(wr), .wr_plane(wr_plane),
    .wr_data(wr_data), .fmode(fmode), .res(res), .nplanes_act(nplanes_act),
    .scroll_odd(scroll_odd), .scroll_even(scroll_even),
    .bpldata(bpldata), .load_pulse(load_pulse), .underrun(underrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NP-1:0] bpl;
    logic          lp;
    logic          ur;
  } exp_t;

  exp_t sb[$];
  exp_t lg[RING];
  int   total = 0;
  int   bad = 0;

  // Reference model: words loaded, load time, latched scrolls, per-cycle
  // shifter-output pixel timeline.
  logic [DW-1:0] m_buf[NP];
  logic [DW-1:0] m_word[NP];
  bit            m_fresh[NP];
  bit            m_pend;
  bit            m_loaded;
  int            m_load_edge;
  int            m_cyc;
  int            m_so;
  int            m_se;
  bit [NP-1:0]   m_ring[RING];

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      m_buf[p] = '0; m_word[p] = '0; m_fresh[p] = 1'b0;
    end
    m_pend = 1'b0; m_loaded = 1'b0; m_load_edge = 0; m_cyc = 0;
    m_so = 0; m_se = 0;
  endtask

  function automatic logic [DW-1:0] keep_mask(input logic [1:0] fm);
    int w;
    w = (fm == 2'b00) ? 16 : ((fm == 2'b11) ? 64 : 32);
    if (w > DW) w = DW;
    return ~((64'd1 << (DW - w)) - 64'd1);
  endfunction

  // Expected outputs for the current cycle, from the current inputs.
  task automatic push_exp();
    exp_t e;
    int d, k, idx, s;
    bit b, st;
    d = (res == 2'b00) ? 4 : ((res == 2'b01) ? 2 : 1);
    for (int p = 0; p < NP; p++) begin
      b = 1'b0;
      if (m_loaded) begin
        k = (m_cyc - m_load_edge) / d;
        if (k < DW) b = m_word[p][DW-1-k];
      end
      m_ring[m_cyc % RING][p] = b;
    end
    e = '0;
    for (int p = 0; p < NP; p++) begin
      s = (p % 2 == 0) ? m_so : m_se;
      idx = m_cyc - 1 - s;
      if ((p < int'(nplanes_act)) && (idx >= 0)) e.bpl[p] = m_ring[idx % RING][p];
    end
    st = 1'b0;
    for (int p = 1; p < NP; p++)
      if ((p < int'(nplanes_act)) && !m_fresh[p]) st = 1'b1;
    e.lp = m_pend;
    e.ur = m_pend & st;
    sb.push_back(e);
  endtask

  // State update at a clock edge, using the inputs held through that edge.
  task automatic model_edge();
    if (m_pend) begin
      for (int p = 0; p < NP; p++) begin
        m_word[p] = m_buf[p];
        m_fresh[p] = 1'b0;
      end
      m_load_edge = m_cyc + 1;
      m_loaded = 1'b1;
      m_so = int'(scroll_odd);
      m_se = int'(scroll_even);
    end
    if (wr && (int'(wr_plane) < NP)) begin
      m_buf[wr_plane] = wr_data & keep_mask(fmode);
      m_fresh[wr_plane] = 1'b1;
    end
    m_pend = wr && (wr_plane == 3'd0);
    m_cyc++;
  endtask

  task automatic cyc();
    push_exp();
    #3;
    lg[m_cyc % RING] = {bpldata, load_pulse, underrun};
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic wr_cyc(input int pl, input logic [DW-1:0] d);
    wr = 1'b1; wr_plane = 3'(pl); wr_data = d;
    cyc();
    wr = 1'b0;
  endtask

  task automatic idle(input int n);
    wr = 1'b0;
    repeat (n) cyc();
  endtask

  function automatic logic [DW-1:0] w16(input logic [15:0] v);
    return {v, {(DW-16){1'b0}}};
  endfunction

  function automatic int pat(input int p, input int start, input int n);
    int v = 0;
    for (int i = 0; i < n; i++) v = (v << 1) | int'(lg[(start + i) % RING].bpl[p]);
    return v;
  endfunction

  function automatic int pat_lp(input int start, input int n);
    int v = 0;
    for (int i = 0; i < n; i++) v = (v << 1) | int'(lg[(start + i) % RING].lp);
    return v;
  endfunction

  function automatic int ones(input int p, input int start, input int n);
    int c = 0;
    for (int i = 0; i < n; i++) c += int'(lg[(start + i) % RING].bpl[p]);
    return c;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: compare every presented output cycle against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      if ({bpldata, load_pulse, underrun} !== e) begin
        bad++;
        $display("FAIL scoreboard t=%0t: got bpl=%b lp=%b ur=%b, expected bpl=%b lp=%b ur=%b",
                 $time, bpldata, load_pulse, underrun, e.bpl, e.lp, e.ur);
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, w2, n;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_bpldata", int'(bpldata), 0);
    chk("reset_load_pulse", int'(load_pulse), 0);
    chk("reset_underrun", int'(underrun), 0);

    // Single plane, shres, 16-bit fetch
    res = 2'b10; fmode = 2'b00; nplanes_act = 4'd1;
    scroll_odd = '0; scroll_even = '0;
    reset_n = 1'b1;
    w = m_cyc;
    wr_cyc(0, w16(16'hA000));
    idle(22);
    chk("t1_pixels", pat(0, w + 2, 6), 6'b010100);
    chk("t1_load_pulse", pat_lp(w, 4), 4'b0100);
    chk("t1_underrun", int'(lg[(w + 1) % RING].ur), 0);

    // Hires, two planes
    res = 2'b01; nplanes_act = 4'd2;
    wr_cyc(1, w16(16'h8000));
    w = m_cyc;
    wr_cyc(0, w16(16'hC000));
    idle(44);
    chk("t2_plane0", pat(0, w + 2, 6), 6'b011110);
    chk("t2_plane1", pat(1, w + 2, 4), 4'b0110);
    chk("t2_underrun", int'(lg[(w + 1) % RING].ur), 0);

    // Lores, four planes enabled, only two written
    res = 2'b00; nplanes_act = 4'd4;
    wr_cyc(1, w16(16'h8000));
    w = m_cyc;
    wr_cyc(0, w16(16'h8000));
    idle(80);
    chk("t3_underrun", int'(lg[(w + 1) % RING].ur), 1);
    chk("t3_load_pulse", int'(lg[(w + 1) % RING].lp), 1);
    chk("t3_plane0", pat(0, w + 2, 6), 6'b011110);
    chk("t3_plane2_zero", ones(2, w + 2, 20), 0);
    chk("t3_plane3_zero", ones(3, w + 2, 20), 0);

    // Odd playfield scroll of 5
    res = 2'b10; nplanes_act = 4'd2; scroll_odd = 8'd5; scroll_even = 8'd0;
    wr_cyc(1, w16(16'h8000));
    w = m_cyc;
    wr_cyc(0, w16(16'h8000));
    idle(40);
    chk("t4_plane1", pat(1, w + 2, 3), 3'b010);
    chk("t4_plane0", pat(0, w + 2, 8), 8'b00000010);

    // 64-bit fetch reaches the last pixel; 16-bit fetch masks it away
    scroll_odd = 8'd0; nplanes_act = 4'd1; fmode = 2'b11;
    w = m_cyc;
    wr_cyc(0, 64'h1);
    idle(70);
    chk("t5_pixel63", int'(lg[(w + 66) % RING].bpl[0]), 1);
    chk("t5_single", ones(0, w + 2, 69), 1);
    fmode = 2'b00;
    w = m_cyc;
    wr_cyc(0, 64'h1);
    idle(70);
    chk("t5_masked", ones(0, w + 2, 69), 0);

    // Plane-1 write during the load cycle goes to the next load
    nplanes_act = 4'd2; scroll_odd = '0; scroll_even = '0;
    w = m_cyc;
    wr_cyc(0, w16(16'h8000));
    wr_cyc(1, w16(16'hFFFF));
    idle(20);
    chk("t6_underrun_first", int'(lg[(w + 1) % RING].ur), 1);
    chk("t6_old_word", pat(1, w + 3, 3), 3'b100);
    w2 = m_cyc;
    wr_cyc(0, w16(16'h8000));
    idle(20);
    chk("t6_underrun_second", int'(lg[(w2 + 1) % RING].ur), 0);
    chk("t6_new_word", pat(1, w2 + 3, 3), 3'b111);

    // Back-to-back plane-0 writes, second load cuts the first word short
    nplanes_act = 4'd1;
    w = m_cyc;
    wr_cyc(0, w16(16'hF000));
    wr_cyc(0, w16(16'h8000));
    idle(20);
    chk("t7_two_pulses", pat_lp(w, 4), 4'b0110);
    chk("t7_pixels", pat(0, w + 3, 4), 4'b1100);

    // Reset mid-line
    nplanes_act = 4'd8;
    for (int p = 7; p >= 1; p--) wr_cyc(p, w16(16'hFFFF));
    w = m_cyc;
    wr_cyc(0, w16(16'hFFFF));
    idle(6);
    chk("t8_active_before_reset", int'(lg[(w + 6) % RING].bpl), 255);
    #1 reset_n = 1'b0;
    #1;
    chk("t8_reset_bpldata", int'(bpldata), 0);
    chk("t8_reset_load_pulse", int'(load_pulse), 0);
    @(posedge clk);
    #1;
    model_reset();
    reset_n = 1'b1;
    idle(10);

    // Randomized traffic
    for (int s = 0; s < 30; s++) begin
      res = 2'($urandom_range(0, 3));
      scroll_odd  = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 40));
      scroll_even = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 40));
      n = int'($urandom_range(10, 60));
      for (int i = 0; i < n; i++) begin
        nplanes_act = 4'($urandom_range(0, 8));
        fmode = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) scroll_odd = 8'($urandom_range(0, 63));
        if ($urandom_range(0, 7) == 0) scroll_even = 8'($urandom_range(0, 63));
        if ($urandom_range(0, 2) == 0) idle(1);
        else if ($urandom_range(0, 3) == 0) wr_cyc(0, {$urandom, $urandom});
        else wr_cyc(int'($urandom_range(0, 7)), {$urandom, $urandom});
      end
      idle(270);
    end

    idle(2);
    chk("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
